hsaf_tdm_sequencer: RTL and testbench

- Control FSM for a time-multiplexed HSAF-LMS datapath: one shared MAC, a tap RAM, a linear-weight RAM and a spline q-weight RAM.
- Accepts one input sample per valid/ready handshake.
- Sequences, in order: spline interpolation, tap write, linear FIR, error latch, linear weight update, q-weight update.
- Signals completion with out_valid/out_ready. Sits between the sample source and the datapath and owns every address, enable and write strobe.

---
 rtl/hsaf_pkg.sv | 27 ++
 rtl/hsaf_circ_addr.sv | 14 +
 rtl/hsaf_tdm_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_hsaf_tdm_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsaf_pkg.sv
// Shared sizing, phase lengths and state encoding for the HSAF-LMS
// time-multiplexed sequencer.
package hsaf_pkg;

   localparam int unsigned L_ORD      = 32;
   localparam int unsigned Q_ORD      = 4;
   localparam int unsigned Q          = 13;
   localparam int unsigned SPAN_WIDTH = $clog2(Q + Q_ORD);
   localparam int unsigned AW         = $clog2(L_ORD);

   localparam int unsigned SPLINE_LEN = Q_ORD;
   localparam int unsigned LIN_LEN    = L_ORD;
   localparam int unsigned TOTAL_LAT  = 2 * Q_ORD + 2 * L_ORD + 3;

   typedef enum logic [3:0] {
      INIT,
      IDLE,
      SPLINE,
      TAPWR,
      LIN,
      ERR,
      WUPD,
      QUPD,
      DONE
   } state_t;

endpackage

// File: rtl/hsaf_circ_addr.sv
// Circular tap addressing: newest-first walk back from the write head,
// wrapping modulo the tap RAM depth.
module hsaf_circ_addr
   import hsaf_pkg::*;
(
   input  logic [AW-1:0] head,
   input  logic [AW-1:0] offset,
   output logic [AW-1:0] addr_c
);

   // AW-bit subtraction wraps naturally because L_ORD is a power of two
   assign addr_c = head - offset;

endmodule

// File: rtl/hsaf_tdm_sequencer.sv
// Control FSM for the HSAF-LMS datapath: sequences spline interpolation,
// tap write, linear FIR, error latch and both weight updates per sample.
module hsaf_tdm_sequencer
   import hsaf_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SPAN_WIDTH-1:0] span_ind,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  mac_clr,
   output logic                  mac_en,
   output logic                  mac_src,
   output logic [AW-1:0]         tap_addr,
   output logic                  tap_we,
   output logic [AW-1:0]         coef_addr,
   output logic                  w_we,
   output logic [SPAN_WIDTH-1:0] qw_addr,
   output logic                  qw_we,
   output logic [1:0]            u_idx,
   output logic                  err_latch,
   output logic                  init_mode,
   output logic                  span_sat
);

   localparam logic [AW-1:0]         SPLINE_LAST = AW'(SPLINE_LEN - 1);
   localparam logic [AW-1:0]         LIN_LAST    = AW'(LIN_LEN - 1);
   localparam logic [AW:0]           QRAM_DEPTH  = (AW + 1)'(Q + Q_ORD);
   localparam logic [SPAN_WIDTH-1:0] SPAN_MAX    = SPAN_WIDTH'(Q);

   state_t                  state, state_d;
   logic [AW-1:0]           cnt, cnt_d;
   logic [AW-1:0]           head, head_d;
   logic [AW-1:0]           head_inc;
   logic [AW-1:0]           circ_addr;
   logic [SPAN_WIDTH-1:0]   sp, sp_d;
   logic [SPAN_WIDTH-1:0]   qw_span_addr;
   logic                    span_sat_d;

   assign head_inc     = head + AW'(1);
   assign qw_span_addr = sp + SPAN_WIDTH'(cnt);

   hsaf_circ_addr u_circ_addr (
      .head   (head),
      .offset (cnt),
      .addr_c (circ_addr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= INIT;
         cnt      <= '0;
         head     <= '0;
         sp       <= '0;
         span_sat <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         head     <= head_d;
         sp       <= sp_d;
         span_sat <= span_sat_d;
      end
   end

   // Strobes are held low for as long as reset is asserted
   always_comb begin
      state_d    = state;
      cnt_d      = cnt + AW'(1);
      head_d     = head;
      sp_d       = sp;
      span_sat_d = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      mac_clr    = 1'b0;
      mac_en     = 1'b0;
      mac_src    = 1'b0;
      tap_addr   = '0;
      tap_we     = 1'b0;
      coef_addr  = '0;
      w_we       = 1'b0;
      qw_addr    = '0;
      qw_we      = 1'b0;
      u_idx      = '0;
      err_latch  = 1'b0;
      init_mode  = 1'b0;

      if (!reset) begin
         unique case (state)
            INIT: begin
               init_mode = 1'b1;
               tap_we    = 1'b1;
               w_we      = 1'b1;
               tap_addr  = cnt;
               coef_addr = cnt;
               if ({1'b0, cnt} < QRAM_DEPTH) begin
                  qw_we   = 1'b1;
                  qw_addr = SPAN_WIDTH'(cnt);
               end
               if (cnt == LIN_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            IDLE: begin
               in_ready = 1'b1;
               cnt_d    = '0;
               if (in_valid) begin
                  state_d    = SPLINE;
                  sp_d       = (span_ind > SPAN_MAX) ? SPAN_MAX : span_ind;
                  span_sat_d = (span_ind > SPAN_MAX);
               end
            end
            SPLINE: begin
               mac_en  = 1'b1;
               mac_clr = (cnt == '0);
               qw_addr = qw_span_addr;
               u_idx   = 2'(cnt);
               if (cnt == SPLINE_LAST) begin
                  state_d = TAPWR;
                  cnt_d   = '0;
               end
            end
            TAPWR: begin
               tap_we   = 1'b1;
               tap_addr = head_inc;
               head_d   = head_inc;
               state_d  = LIN;
               cnt_d    = '0;
            end
            LIN: begin
               mac_src   = 1'b1;
               mac_en    = 1'b1;
               mac_clr   = (cnt == '0);
               tap_addr  = circ_addr;
               coef_addr = cnt;
               if (cnt == LIN_LAST) begin
                  state_d = ERR;
                  cnt_d   = '0;
               end
            end
            ERR: begin
               err_latch = 1'b1;
               state_d   = WUPD;
               cnt_d     = '0;
            end
            WUPD: begin
               w_we      = 1'b1;
               tap_addr  = circ_addr;
               coef_addr = cnt;
               if (cnt == LIN_LAST) begin
                  state_d = QUPD;
                  cnt_d   = '0;
               end
            end
            QUPD: begin
               qw_we   = 1'b1;
               qw_addr = qw_span_addr;
               u_idx   = 2'(cnt);
               if (cnt == SPLINE_LAST) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end
            end
            DONE: begin
               out_valid = 1'b1;
               cnt_d     = '0;
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = INIT;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hsaf_tdm_sequencer.sv
// Self-checking bench for hsaf_tdm_sequencer: per-cycle output vectors are
// predicted from the per-sample phase schedule and compared every cycle.
module tb_hsaf_tdm_sequencer;
   import hsaf_pkg::*;

   localparam int LEN  = 32;
   localparam int QO   = 4;
   localparam int QMAX = 13;
   localparam int NQW  = 17;

   typedef struct packed {
      logic                  in_ready;
      logic                  out_valid;
      logic                  mac_clr;
      logic                  mac_en;
      logic                  mac_src;
      logic [AW-1:0]         tap_addr;
      logic                  tap_we;
      logic [AW-1:0]         coef_addr;
      logic                  w_we;
      logic [SPAN_WIDTH-1:0] qw_addr;
      logic                  qw_we;
      logic [1:0]            u_idx;
      logic                  err_latch;
      logic                  init_mode;
      logic                  span_sat;
   } ovec_t;

   typedef struct {
      logic [SPAN_WIDTH-1:0] span;
      int                    gap;
      int                    dly;
      logic [SPAN_WIDTH-1:0] exp_sp;
      bit                    exp_sat;
   } vec_t;

   logic                  clk;
   logic                  reset;
   logic                  in_valid;
   logic                  in_ready;
   logic [SPAN_WIDTH-1:0] span_ind;
   logic                  out_valid;
   logic                  out_ready;
   logic                  mac_clr;
   logic                  mac_en;
   logic                  mac_src;
   logic [AW-1:0]         tap_addr;
   logic                  tap_we;
   logic [AW-1:0]         coef_addr;
   logic                  w_we;
   logic [SPAN_WIDTH-1:0] qw_addr;
   logic                  qw_we;
   logic [1:0]            u_idx;
   logic                  err_latch;
   logic                  init_mode;
   logic                  span_sat;

   int total = 0;
   int bad   = 0;
   int ncyc  = 0;
   int head_m = 0;

   hsaf_tdm_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .span_ind  (span_ind),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mac_clr   (mac_clr),
      .mac_en    (mac_en),
      .mac_src   (mac_src),
      .tap_addr  (tap_addr),
      .tap_we    (tap_we),
      .coef_addr (coef_addr),
      .w_we      (w_we),
      .qw_addr   (qw_addr),
      .qw_we     (qw_we),
      .u_idx     (u_idx),
      .err_latch (err_latch),
      .init_mode (init_mode),
      .span_sat  (span_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ovec_t mk_mask(bit tap, bit coef, bit qw, bit u, bit src);
      ovec_t m;
      m = '1;
      if (!tap)  m.tap_addr  = '0;
      if (!coef) m.coef_addr = '0;
      if (!qw)   m.qw_addr   = '0;
      if (!u)    m.u_idx     = '0;
      if (!src)  m.mac_src   = 1'b0;
      return m;
   endfunction

   function automatic logic rbit(bit noise);
      return noise ? 1'($urandom_range(0, 1)) : 1'b0;
   endfunction

   function automatic logic [SPAN_WIDTH-1:0] rspan();
      return SPAN_WIDTH'($urandom);
   endfunction

   // One clock cycle: drive this cycle's inputs just after the edge, compare mid-cycle
   task automatic cyc(input logic rst, input logic iv, input logic [SPAN_WIDTH-1:0] si,
                      input logic ordy, input ovec_t e, input ovec_t m, input string nm);
      ovec_t a;
      @(posedge clk);
      #1;
      reset     = rst;
      in_valid  = iv;
      span_ind  = si;
      out_ready = ordy;
      @(negedge clk);
      a.in_ready  = in_ready;
      a.out_valid = out_valid;
      a.mac_clr   = mac_clr;
      a.mac_en    = mac_en;
      a.mac_src   = mac_src;
      a.tap_addr  = tap_addr;
      a.tap_we    = tap_we;
      a.coef_addr = coef_addr;
      a.w_we      = w_we;
      a.qw_addr   = qw_addr;
      a.qw_we     = qw_we;
      a.u_idx     = u_idx;
      a.err_latch = err_latch;
      a.init_mode = init_mode;
      a.span_sat  = span_sat;
      total++;
      if (((a ^ e) & m) != '0) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h expected=%h care=%h", nm, ncyc, a, e, m);
      end
      if (!a.init_mode) begin
         total++;
         if (int'(a.tap_we) + int'(a.w_we) + int'(a.qw_we) > 1) begin
            bad++;
            $display("FAIL we_excl cycle=%0d got tap/w/qw=%b%b%b expected at most one high",
                     ncyc, a.tap_we, a.w_we, a.qw_we);
         end
      end
      ncyc++;
   endtask

   task automatic check_init();
      ovec_t e;
      for (int k = 0; k < LEN; k++) begin
         e           = '0;
         e.init_mode = 1'b1;
         e.tap_we    = 1'b1;
         e.w_we      = 1'b1;
         e.tap_addr  = AW'(k);
         e.coef_addr = AW'(k);
         if (k < NQW) begin
            e.qw_we   = 1'b1;
            e.qw_addr = SPAN_WIDTH'(k);
         end
         cyc(1'b0, 1'b0, '0, 1'b0, e, mk_mask(1, 1, k < NQW, 0, 0), "init");
      end
      head_m = 0;
   endtask

   // Full sample schedule from the handshake to the DONE acceptance
   task automatic do_sample(input logic [SPAN_WIDTH-1:0] s, input logic [SPAN_WIDTH-1:0] xsp,
                            input bit xsat, input int gap, input int dly, input bit noise,
                            input int abort_lin);
      ovec_t e;
      logic  busy_rdy;
      for (int g = 0; g < gap; g++) begin
         e = '0;
         e.in_ready = 1'b1;
         cyc(1'b0, 1'b0, rspan(), rbit(noise), e, mk_mask(0, 0, 0, 0, 0), "idle");
      end
      e = '0;
      e.in_ready = 1'b1;
      cyc(1'b0, 1'b1, s, rbit(noise), e, mk_mask(0, 0, 0, 0, 0), "accept");

      for (int i = 0; i < QO; i++) begin
         busy_rdy   = noise ? rbit(1) : 1'b1;
         e          = '0;
         e.mac_en   = 1'b1;
         e.mac_clr  = (i == 0);
         e.qw_addr  = SPAN_WIDTH'(int'(xsp) + i);
         e.u_idx    = 2'(i);
         e.span_sat = (i == 0) && xsat;
         cyc(1'b0, rbit(noise), rspan(), busy_rdy, e, mk_mask(0, 0, 1, 1, 1), "spline");
      end

      head_m   = (head_m + 1) % LEN;
      e        = '0;
      e.tap_we = 1'b1;
      e.tap_addr = AW'(head_m);
      cyc(1'b0, rbit(noise), rspan(), 1'b1, e, mk_mask(1, 0, 0, 0, 0), "tapwr");

      for (int i = 0; i < LEN; i++) begin
         if (i == abort_lin) begin
            e = '0;
            cyc(1'b1, 1'b0, '0, 1'b0, e, mk_mask(0, 0, 0, 0, 0), "rst_mid");
            head_m = 0;
            return;
         end
         e           = '0;
         e.mac_en    = 1'b1;
         e.mac_clr   = (i == 0);
         e.mac_src   = 1'b1;
         e.tap_addr  = AW'((head_m - i + LEN) % LEN);
         e.coef_addr = AW'(i);
         cyc(1'b0, rbit(noise), rspan(), 1'b1, e, mk_mask(1, 1, 0, 0, 1), "lin");
      end

      e = '0;
      e.err_latch = 1'b1;
      cyc(1'b0, rbit(noise), rspan(), 1'b1, e, mk_mask(0, 0, 0, 0, 0), "err");

      for (int i = 0; i < LEN; i++) begin
         e           = '0;
         e.w_we      = 1'b1;
         e.tap_addr  = AW'((head_m - i + LEN) % LEN);
         e.coef_addr = AW'(i);
         cyc(1'b0, rbit(noise), rspan(), 1'b1, e, mk_mask(1, 1, 0, 0, 0), "wupd");
      end

      for (int i = 0; i < QO; i++) begin
         e         = '0;
         e.qw_we   = 1'b1;
         e.qw_addr = SPAN_WIDTH'(int'(xsp) + i);
         e.u_idx   = 2'(i);
         cyc(1'b0, rbit(noise), rspan(), 1'b1, e, mk_mask(0, 0, 1, 1, 0), "qupd");
      end

      for (int d = 0; d < dly; d++) begin
         e = '0;
         e.out_valid = 1'b1;
         cyc(1'b0, rbit(noise), rspan(), 1'b0, e, mk_mask(0, 0, 0, 0, 0), "done_wait");
      end
      e = '0;
      e.out_valid = 1'b1;
      cyc(1'b0, rbit(noise), rspan(), 1'b1, e, mk_mask(0, 0, 0, 0, 0), "done_ack");
   endtask

   vec_t tbl[7];

   initial begin
      logic [SPAN_WIDTH-1:0] s;
      logic [SPAN_WIDTH-1:0] xsp;
      reset     = 1'b1;
      in_valid  = 1'b0;
      span_ind  = '0;
      out_ready = 1'b0;

      tbl[0] = '{span: 5'd5,  gap: 0, dly: 0,  exp_sp: 5'd5,  exp_sat: 1'b0};
      tbl[1] = '{span: 5'd16, gap: 0, dly: 0,  exp_sp: 5'd13, exp_sat: 1'b1};
      tbl[2] = '{span: 5'd13, gap: 1, dly: 0,  exp_sp: 5'd13, exp_sat: 1'b0};
      tbl[3] = '{span: 5'd0,  gap: 2, dly: 3,  exp_sp: 5'd0,  exp_sat: 1'b0};
      tbl[4] = '{span: 5'd14, gap: 0, dly: 10, exp_sp: 5'd13, exp_sat: 1'b1};
      tbl[5] = '{span: 5'd31, gap: 0, dly: 1,  exp_sp: 5'd13, exp_sat: 1'b1};
      tbl[6] = '{span: 5'd12, gap: 0, dly: 0,  exp_sp: 5'd12, exp_sat: 1'b0};

      for (int r = 0; r < 3; r++) begin
         cyc(1'b1, 1'b0, '0, 1'b0, '0, mk_mask(0, 0, 0, 0, 0), "reset");
      end
      check_init();

      for (int t = 0; t < 7; t++) begin
         do_sample(tbl[t].span, tbl[t].exp_sp, tbl[t].exp_sat, tbl[t].gap, tbl[t].dly, 1'b0, -1);
      end

      // Randomised samples with in_valid/out_ready noise while busy
      for (int t = 0; t < 20; t++) begin
         s   = rspan();
         xsp = (int'(s) > QMAX) ? SPAN_WIDTH'(QMAX) : s;
         do_sample(s, xsp, int'(s) > QMAX, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, -1);
      end

      // Back-to-back stream with out_ready held high; head wraps past 31
      for (int t = 0; t < 40; t++) begin
         s   = rspan();
         xsp = (int'(s) > QMAX) ? SPAN_WIDTH'(QMAX) : s;
         do_sample(s, xsp, int'(s) > QMAX, 0, 0, 1'b0, -1);
      end

      // Reset mid-LIN drops the sample and reruns the init sweep
      do_sample(5'd7, 5'd7, 1'b0, 1, 0, 1'b0, 10);
      check_init();
      do_sample(5'd3, 5'd3, 1'b0, 2, 0, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
